// File: rtl/e203_exu_dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// e203_exu_dsp_mac_seq
// Sequencer for DSP multiply-accumulate ops. It accepts one op, optionally
// fetches the odd half of a 64-bit rd pair from the register file, fires the
// MAC adder for one cycle, and writes back one or two result halves.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   i_valid/i_ready      op handshake (ready only while idle)
//   i_rdw64              op works on the {rd|1, rd&~1} register pair
//   i_src0               rd value (even half when i_rdw64)
//   i_rdidx, i_itag      destination index and instruction tag
//   i_flush              kill an op still in FETCH/CALC
//   rf_rd_*              regfile read port used to fetch the odd half
//   adder_*              MAC adder request (go pulse, sources) and result
//   wbck_*               writeback port, one beat per result half
//   ov_set               one-cycle pulse to the OV CSR on adder overflow
//   busy                 high whenever an op is in flight
// ---------------------------------------------------------------------------
module e203_exu_dsp_mac_seq #(
   parameter int XLEN   = 32,
   parameter int ITAG_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              i_valid,
   output logic              i_ready,
   input  logic              i_rdw64,
   input  logic [XLEN-1:0]   i_src0,
   input  logic [4:0]        i_rdidx,
   input  logic [ITAG_W-1:0] i_itag,
   input  logic              i_flush,

   output logic              rf_rd_req,
   output logic [4:0]        rf_rd_idx,
   input  logic              rf_rd_rsp_valid,
   input  logic [XLEN-1:0]   rf_rd_data,

   output logic              adder_go,
   output logic [XLEN-1:0]   adder_src0,
   output logic [XLEN-1:0]   adder_src0_1,
   output logic              adder_rdw64,
   input  logic [XLEN-1:0]   adder_wdat,
   input  logic [XLEN-1:0]   adder_wdat_1,
   input  logic              adder_ov,

   output logic              wbck_valid,
   input  logic              wbck_ready,
   output logic [XLEN-1:0]   wbck_wdat,
   output logic [4:0]        wbck_rdidx,
   output logic [ITAG_W-1:0] wbck_itag,
   output logic              ov_set,
   output logic              busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_CALC  = 3'd2;
   localparam logic [2:0] S_WB0   = 3'd3;
   localparam logic [2:0] S_WB1   = 3'd4;

   logic [2:0]        state;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   hi_q;
   logic [4:0]        rdidx_q;
   logic [ITAG_W-1:0] itag_q;
   logic              rdw64_q;
   logic [XLEN-1:0]   res0_q;
   logic [XLEN-1:0]   res1_q;
   logic              ov_set_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         rdidx_q  <= '0;
         itag_q   <= '0;
         rdw64_q  <= 1'b0;
         res0_q   <= '0;
         res1_q   <= '0;
         ov_set_q <= 1'b0;
      end else begin
         ov_set_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  lo_q    <= i_src0;
                  // hi is cleared so a 32-bit op presents 0 as the odd source
                  hi_q    <= '0;
                  rdidx_q <= i_rdw64 ? {i_rdidx[4:1], 1'b0} : i_rdidx;
                  itag_q  <= i_itag;
                  rdw64_q <= i_rdw64;
                  state   <= i_rdw64 ? S_FETCH : S_CALC;
               end
            end
            S_FETCH: begin
               if (i_flush) begin
                  state <= S_IDLE;
               end else if (rf_rd_rsp_valid) begin
                  hi_q  <= rf_rd_data;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               if (i_flush) begin
                  state <= S_IDLE;
               end else begin
                  res0_q   <= adder_wdat;
                  res1_q   <= adder_wdat_1;
                  ov_set_q <= adder_ov;
                  state    <= S_WB0;
               end
            end
            S_WB0: begin
               if (wbck_ready) state <= rdw64_q ? S_WB1 : S_IDLE;
            end
            S_WB1: begin
               if (wbck_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      i_ready      = (state == S_IDLE);
      busy         = (state != S_IDLE);
      rf_rd_req    = 1'b0;
      rf_rd_idx    = '0;
      adder_go     = 1'b0;
      adder_src0   = '0;
      adder_src0_1 = '0;
      adder_rdw64  = 1'b0;
      wbck_valid   = 1'b0;
      wbck_wdat    = '0;
      wbck_rdidx   = '0;
      wbck_itag    = '0;
      case (state)
         S_FETCH: begin
            rf_rd_req = 1'b1;
            rf_rd_idx = {rdidx_q[4:1], 1'b1};
         end
         S_CALC: begin
            adder_go     = 1'b1;
            adder_src0   = lo_q;
            adder_src0_1 = hi_q;
            adder_rdw64  = rdw64_q;
         end
         S_WB0: begin
            wbck_valid = 1'b1;
            wbck_wdat  = res0_q;
            wbck_rdidx = rdidx_q;
            wbck_itag  = itag_q;
         end
         S_WB1: begin
            wbck_valid = 1'b1;
            wbck_wdat  = res1_q;
            wbck_rdidx = {rdidx_q[4:1], 1'b1};
            wbck_itag  = itag_q;
         end
         default: ;
      endcase
   end

   assign ov_set = ov_set_q;

endmodule

// File: tb/tb_e203_exu_dsp_mac_seq.sv
// ---------------------------------------------------------------------------
// Directed testbench for e203_exu_dsp_mac_seq. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point, so every
// check sees the state settled by the preceding edge.
// ---------------------------------------------------------------------------
module tb_e203_exu_dsp_mac_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid, i_ready, i_rdw64, i_flush;
   logic [31:0] i_src0;
   logic [4:0]  i_rdidx;
   logic [1:0]  i_itag;
   logic        rf_rd_req, rf_rd_rsp_valid;
   logic [4:0]  rf_rd_idx;
   logic [31:0] rf_rd_data;
   logic        adder_go, adder_rdw64, adder_ov;
   logic [31:0] adder_src0, adder_src0_1, adder_wdat, adder_wdat_1;
   logic        wbck_valid, wbck_ready, ov_set, busy;
   logic [31:0] wbck_wdat;
   logic [4:0]  wbck_rdidx;
   logic [1:0]  wbck_itag;

   int vectors    = 0;
   int miscompares = 0;
   int hs_cnt     = 0;
   int ov_cnt     = 0;
   int hs_base;
   int ov_base;

   e203_exu_dsp_mac_seq #(.XLEN(32), .ITAG_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(i_valid), .i_ready(i_ready), .i_rdw64(i_rdw64),
      .i_src0(i_src0), .i_rdidx(i_rdidx), .i_itag(i_itag), .i_flush(i_flush),
      .rf_rd_req(rf_rd_req), .rf_rd_idx(rf_rd_idx),
      .rf_rd_rsp_valid(rf_rd_rsp_valid), .rf_rd_data(rf_rd_data),
      .adder_go(adder_go), .adder_src0(adder_src0), .adder_src0_1(adder_src0_1),
      .adder_rdw64(adder_rdw64), .adder_wdat(adder_wdat),
      .adder_wdat_1(adder_wdat_1), .adder_ov(adder_ov),
      .wbck_valid(wbck_valid), .wbck_ready(wbck_ready), .wbck_wdat(wbck_wdat),
      .wbck_rdidx(wbck_rdidx), .wbck_itag(wbck_itag),
      .ov_set(ov_set), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wbck_valid && wbck_ready) hs_cnt++;
      if (ov_set) ov_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rdw64, input logic [4:0] idx,
                        input logic [31:0] src, input logic [1:0] tag);
      i_valid = 1'b1;
      i_rdw64 = rdw64;
      i_rdidx = idx;
      i_src0  = src;
      i_itag  = tag;
   endtask

   initial begin
      rst_n = 1'b0;
      i_valid = 0; i_rdw64 = 0; i_src0 = '0; i_rdidx = '0; i_itag = '0; i_flush = 0;
      rf_rd_rsp_valid = 0; rf_rd_data = '0;
      adder_wdat = '0; adder_wdat_1 = '0; adder_ov = 0; wbck_ready = 0;

      // ---- reset state ----
      #12;
      chk("rst_i_ready", i_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wbck_valid", wbck_valid, 0);
      chk("rst_adder_go", adder_go, 0);
      chk("rst_rf_rd_req", rf_rd_req, 0);
      chk("rst_ov_set", ov_set, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // ---- 32-bit op ----
      issue(0, 5'd5, 32'h10, 2'd1);
      adder_wdat = 32'h123; adder_wdat_1 = 32'h999; wbck_ready = 1;
      step();
      i_valid = 0;
      chk("t1_adder_go", adder_go, 1);
      chk("t1_adder_src0", adder_src0, 32'h10);
      chk("t1_adder_src0_1", adder_src0_1, 0);
      chk("t1_adder_rdw64", adder_rdw64, 0);
      chk("t1_i_ready_busy", i_ready, 0);
      chk("t1_rf_rd_req", rf_rd_req, 0);
      step();
      chk("t1_adder_go_low", adder_go, 0);
      chk("t1_wbck_valid", wbck_valid, 1);
      chk("t1_wbck_wdat", wbck_wdat, 32'h123);
      chk("t1_wbck_rdidx", wbck_rdidx, 5);
      chk("t1_wbck_itag", wbck_itag, 1);
      chk("t1_ov_set", ov_set, 0);
      step();
      chk("t1_i_ready_back", i_ready, 1);
      chk("t1_wbck_done", wbck_valid, 0);
      chk("t1_busy_done", busy, 0);

      // ---- 64-bit op, response three cycles into the request ----
      issue(1, 5'd7, 32'h11112222, 2'd2);
      adder_wdat = 32'hCAFE0001; adder_wdat_1 = 32'hBEEF0002;
      step();
      i_valid = 0;
      chk("t2_rf_rd_req", rf_rd_req, 1);
      chk("t2_rf_rd_idx", rf_rd_idx, 7);
      chk("t2_no_go_in_fetch", adder_go, 0);
      step();
      chk("t2_req_held1", rf_rd_req, 1);
      step();
      chk("t2_req_held2", rf_rd_req, 1);
      rf_rd_rsp_valid = 1; rf_rd_data = 32'hAAAA5555;
      step();
      rf_rd_rsp_valid = 0; rf_rd_data = '0;
      chk("t2_adder_go", adder_go, 1);
      chk("t2_adder_src0", adder_src0, 32'h11112222);
      chk("t2_adder_src0_1", adder_src0_1, 32'hAAAA5555);
      chk("t2_adder_rdw64", adder_rdw64, 1);
      chk("t2_rf_rd_req_low", rf_rd_req, 0);
      step();
      chk("t2_wb0_valid", wbck_valid, 1);
      chk("t2_wb0_rdidx", wbck_rdidx, 6);
      chk("t2_wb0_wdat", wbck_wdat, 32'hCAFE0001);
      chk("t2_wb0_itag", wbck_itag, 2);
      step();
      chk("t2_wb1_valid", wbck_valid, 1);
      chk("t2_wb1_rdidx", wbck_rdidx, 7);
      chk("t2_wb1_wdat", wbck_wdat, 32'hBEEF0002);
      step();
      chk("t2_idle", i_ready, 1);

      // ---- backpressure in WB0; i_valid while busy is ignored ----
      hs_base = hs_cnt;
      issue(0, 5'd9, 32'h1, 2'd3);
      adder_wdat = 32'h5A5A; wbck_ready = 0;
      step();
      chk("t3_src0_1_cleared", adder_src0_1, 0);
      issue(1, 5'd20, 32'hFFFF, 2'd0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("t3_hold_valid", wbck_valid, 1);
         chk("t3_hold_wdat", wbck_wdat, 32'h5A5A);
         chk("t3_hold_rdidx", wbck_rdidx, 9);
         chk("t3_hold_itag", wbck_itag, 3);
         if (i == 3) begin
            i_valid = 0;
            wbck_ready = 1;
         end
         step();
      end
      chk("t3_idle", i_ready, 1);
      chk("t3_single_write", hs_cnt - hs_base, 1);

      // ---- saturation / ov_set pulse ----
      ov_base = ov_cnt;
      issue(0, 5'd3, 32'h7FFFFFF0, 2'd0);
      adder_wdat = 32'h7FFFFFFF; adder_ov = 1; wbck_ready = 0;
      step();
      i_valid = 0;
      chk("t4_no_ov_in_calc", ov_set, 0);
      step();
      adder_ov = 0;
      chk("t4_ov_set", ov_set, 1);
      chk("t4_wdat", wbck_wdat, 32'h7FFFFFFF);
      step();
      chk("t4_ov_one_cycle", ov_set, 0);
      wbck_ready = 1;
      step();
      step();
      chk("t4_ov_count", ov_cnt - ov_base, 1);

      // ---- flush in FETCH and in CALC ----
      hs_base = hs_cnt;
      ov_base = ov_cnt;
      adder_ov = 1;
      issue(1, 5'd4, 32'h5, 2'd1);
      step();
      i_valid = 0;
      chk("t5_in_fetch", rf_rd_req, 1);
      i_flush = 1;
      rf_rd_rsp_valid = 1; rf_rd_data = 32'h1234;
      step();
      i_flush = 0;
      rf_rd_rsp_valid = 0;
      chk("t5_flush_idle", i_ready, 1);
      chk("t5_flush_busy", busy, 0);
      chk("t5_flush_no_wb", wbck_valid, 0);
      issue(0, 5'd8, 32'h6, 2'd1);
      step();
      i_valid = 0;
      i_flush = 1;
      step();
      i_flush = 0;
      chk("t5_calc_flush_idle", i_ready, 1);
      chk("t5_calc_flush_ov", ov_set, 0);
      step();
      step();
      adder_ov = 0;
      chk("t5_flush_hs", hs_cnt - hs_base, 0);
      chk("t5_flush_ov", ov_cnt - ov_base, 0);

      // ---- reset during WB1 (response already present at accept) ----
      rf_rd_rsp_valid = 1; rf_rd_data = 32'h0F0F0F0F;
      adder_wdat = 32'h11; adder_wdat_1 = 32'h22; wbck_ready = 1;
      issue(1, 5'd13, 32'h9, 2'd2);
      step();
      i_valid = 0;
      step();
      rf_rd_rsp_valid = 0;
      chk("t6_src0_1", adder_src0_1, 32'h0F0F0F0F);
      step();
      chk("t6_wb0_rdidx", wbck_rdidx, 12);
      step();
      wbck_ready = 0;
      chk("t6_wb1_valid", wbck_valid, 1);
      chk("t6_wb1_rdidx", wbck_rdidx, 13);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_wbck_valid", wbck_valid, 0);
      chk("t6_rst_i_ready", i_ready, 1);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_wdat", wbck_wdat, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t6_post_rst_idle", i_ready, 1);
      chk("t6_post_rst_ov", ov_set, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
